// File: rtl/packet_buffer_read_arbiter.sv
// Two-requester read arbiter in front of the packet buffer RAM driver: serialises reads,
// routes each byte to its originator and aborts hung reads. Define
// PACKET_BUFFER_ARB_ROUND_ROBIN_EN for round-robin arbitration (default: B over A).
module packet_buffer_read_arbiter #(
  parameter int RAM_SIZE       = 2048,
  parameter int BYTE_LEN       = 8,
  parameter int TIMEOUT_CYCLES = 16,
  localparam int AW            = $clog2(RAM_SIZE)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                rd_req_a,
  input  logic [AW-1:0]       rd_addr_a,
  output logic                rd_ready_a,
  output logic [BYTE_LEN-1:0] rd_out_a,
  input  logic                rd_req_b,
  input  logic [AW-1:0]       rd_addr_b,
  output logic                rd_ready_b,
  output logic [BYTE_LEN-1:0] rd_out_b,
  output logic                ram_read_req,
  output logic [AW-1:0]       ram_read_addr,
  input  logic                ram_read_ready,
  input  logic [BYTE_LEN-1:0] ram_read_out,
  output logic [1:0]          grant,
  output logic                timeout_err
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_RESP} state_t;

  state_t              state, state_nxt;
  logic [CW-1:0]       tmo_cnt, tmo_cnt_nxt;
  logic                any_req, pick_b, timeout_hit, read_done;
  logic [BYTE_LEN-1:0] resp_data;

  logic                req_nxt, rdy_a_nxt, rdy_b_nxt, terr_nxt;
  logic [AW-1:0]       addr_nxt;
  logic [1:0]          grant_nxt;
  logic [BYTE_LEN-1:0] out_a_nxt, out_b_nxt;

  assign any_req     = rd_req_a | rd_req_b;
  assign timeout_hit = (tmo_cnt == CW'(TIMEOUT_CYCLES - 1));
  assign read_done   = ram_read_ready | timeout_hit;
  // An aborted read still answers the requester, with zero data.
  assign resp_data   = ram_read_ready ? ram_read_out : '0;

`ifdef PACKET_BUFFER_ARB_ROUND_ROBIN_EN
  logic prefer_b;

  assign pick_b = rd_req_b & (~rd_req_a | prefer_b);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prefer_b <= 1'b0;
    end else if (state == S_IDLE && any_req) begin
      prefer_b <= ~pick_b;
    end
  end
`else
  // Ethernet TX is timing-critical, so B always wins a tie.
  assign pick_b = rd_req_b;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      tmo_cnt <= '0;
    end else begin
      state   <= state_nxt;
      tmo_cnt <= tmo_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (any_req) state_nxt = S_READ;
      S_READ:  if (read_done) state_nxt = S_RESP;
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    tmo_cnt_nxt = tmo_cnt;
    grant_nxt   = grant;
    addr_nxt    = ram_read_addr;
    req_nxt     = ram_read_req;
    rdy_a_nxt   = 1'b0;
    rdy_b_nxt   = 1'b0;
    terr_nxt    = 1'b0;
    out_a_nxt   = rd_out_a;
    out_b_nxt   = rd_out_b;
    case (state)
      S_IDLE: begin
        if (any_req) begin
          grant_nxt   = pick_b ? 2'b10 : 2'b01;
          addr_nxt    = pick_b ? rd_addr_b : rd_addr_a;
          req_nxt     = 1'b1;
          tmo_cnt_nxt = '0;
        end
      end
      S_READ: begin
        if (read_done) begin
          req_nxt  = 1'b0;
          terr_nxt = ~ram_read_ready;
          if (grant[1]) begin
            out_b_nxt = resp_data;
            rdy_b_nxt = 1'b1;
          end else begin
            out_a_nxt = resp_data;
            rdy_a_nxt = 1'b1;
          end
        end else begin
          tmo_cnt_nxt = tmo_cnt + 1'b1;
        end
      end
      S_RESP: begin
        // Requests are not sampled here, giving the finished requester an edge to drop.
        grant_nxt = 2'b00;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grant         <= 2'b00;
      ram_read_addr <= '0;
      ram_read_req  <= 1'b0;
      rd_ready_a    <= 1'b0;
      rd_ready_b    <= 1'b0;
      rd_out_a      <= '0;
      rd_out_b      <= '0;
      timeout_err   <= 1'b0;
    end else begin
      grant         <= grant_nxt;
      ram_read_addr <= addr_nxt;
      ram_read_req  <= req_nxt;
      rd_ready_a    <= rdy_a_nxt;
      rd_ready_b    <= rdy_b_nxt;
      rd_out_a      <= out_a_nxt;
      rd_out_b      <= out_b_nxt;
      timeout_err   <= terr_nxt;
    end
  end

endmodule

// File: doc/packet_buffer_read_arbiter.md
Name: packet_buffer_read_arbiter

Overview:
- Shares the single read port of the packet buffer RAM driver between two requesters: A (UART dump engine) and B (Ethernet transmit path).
- Each requester keeps the driver's own handshake (level req / addr in, one-cycle ready / data out), so existing clients connect unchanged.
- Serialises reads, routes each response to the originator and guards against a hung RAM with a timeout.

Parameters:
- RAM_SIZE, PACKET_BUFFER_SIZE, buffer depth in bytes; address width AW = clog2(RAM_SIZE).
- TIMEOUT_CYCLES, 16, maximum cycles in READ before the read is aborted; minimum 2.

Ports:
- clk  in  1  system clock (50 MHz domain).
- reset  in  1  asynchronous, active-low reset.
- rd_req_a  in  1  requester A read request, level, held until rd_ready_a.
- rd_addr_a  in  AW  requester A address, stable while rd_req_a is high.
- rd_ready_a  out  1  one-cycle pulse: rd_out_a is valid.
- rd_out_a  out  BYTE_LEN  read data to A.
- rd_req_b, rd_addr_b, rd_ready_b, rd_out_b: same as A, for requester B.
- ram_read_req  out  1  to RAM driver, level.
- ram_read_addr  out  AW  to RAM driver.
- ram_read_ready  in  1  RAM driver data-valid pulse.
- ram_read_out  in  BYTE_LEN  RAM driver data.
- grant  out  2  one-hot owner of the current read ({B,A}); 2'b00 when idle.
- timeout_err  out  1  one-cycle pulse when a read is aborted.

Behaviour:
- Reset: asynchronous and immediate, including mid-read.
  - State goes to IDLE.
  - ram_read_req, rd_ready_a/b, timeout_err and grant go to 0.
  - rd_out_a/b and ram_read_addr go to 0; the round-robin pointer selects A.
  - A read in flight is abandoned; a late ram_read_ready after reset release is ignored in IDLE.
- States: IDLE, READ, RESP. All outputs are registered.
- IDLE:
  - If rd_req_a and/or rd_req_b is sampled high at an edge, the winner is chosen.
  - At the same edge: grant is set, ram_read_addr is latched from the winner's address, ram_read_req goes to 1, the timeout counter is cleared and the state moves to READ.
- READ:
  - ram_read_req stays high and ram_read_addr stays stable.
  - If ram_read_ready is sampled high: ram_read_out is latched into the granted requester's rd_out_x, rd_ready_x is set for exactly one cycle, ram_read_req drops and the state moves to RESP.
  - Else, if the counter reaches TIMEOUT_CYCLES-1: rd_out_x is set to 0, rd_ready_x pulses, timeout_err pulses, ram_read_req drops and the state moves to RESP.
  - Else the counter increments.
- RESP:
  - Lasts one cycle; grant clears and the state returns to IDLE.
  - Requests are not sampled in RESP, so the completing requester has one edge to deassert.
- Latency: request sampled at edge N, ram_read_req high after N. If the RAM answers on edge N+1, rd_ready_x is high in the cycle after edge N+2.
  - Back-to-back throughput: one byte per 4 cycles with a 1-cycle RAM.
- Non-granted requester: its rd_ready stays 0 and its rd_out holds its last value. A request held during another's read is served next; requests are never dropped.
- Requester dropping rd_req during READ: the read still completes and the ready pulse is still delivered. Requesters must not do this.
- Arbitration without the optional feature: fixed priority, B (Ethernet, timing-critical) beats A.
- ram_read_ready sampled in IDLE or RESP is ignored.

Optional Feature:
- Macro: PACKET_BUFFER_ARB_ROUND_ROBIN_EN.
- Defined:
  - On a simultaneous request, the requester not served last wins; the pointer updates on each grant.
  - A single requester always wins regardless of the pointer.
  - After reset, A is preferred first.
- Undefined: fixed priority as in Behaviour, B before A; the pointer logic is absent.

Test Plan:
- Single A read, addr 0x010, RAM returns 0x5A one cycle after ram_read_req -> ram_read_addr=0x010; rd_ready_a pulses once 3 edges after the request with rd_out_a=0x5A; grant=01 during READ; rd_ready_b never asserts.
- A and B assert together (A addr 0x001, B addr 0x002), feature off -> B is served first, then A; RAM sees addresses 0x002 then 0x001; each ready pulse goes only to its owner.
- Same stimulus, feature on, both held for 4 reads each -> grants alternate A, B, A, B, ... starting with A after reset.
- RAM never asserts ram_read_ready, TIMEOUT_CYCLES=16 -> after 16 cycles in READ: timeout_err pulses once, the requester gets its ready pulse with data 0x00, and the next request is served normally.
- reset driven low mid-READ (asynchronously, between edges) -> ram_read_req and grant drop before the next edge; a stray ram_read_ready after release produces no ready pulse.
- B streams 73 consecutive addresses 0..72 while A is idle -> 73 ready pulses on B with data matching the RAM model in order, 4 cycles per byte.
